// File: rtl/final2_soc_pio_pkg.sv
// Shared constants for the final2_soc parallel I/O slave: register offsets
// and edge-capture modes.
package final2_soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/final2_soc_pio_ext_if.sv
// Avalon-MM slave bus bundle for the final2_soc PIO block.
interface final2_soc_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/final2_soc_pio_sync.sv
// Multi-stage input synchroniser for asynchronous pins, synchronous reset to 0.
module final2_soc_pio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/final2_soc_pio_ext.sv
// Bidirectional Avalon-MM PIO: per-pin direction, atomic set/clear,
// synchronised inputs, per-bit edge capture and a maskable level irq.
module final2_soc_pio_ext
  import final2_soc_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  final2_soc_pio_ext_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic [WIDTH-1:0]      out_port,
  output logic [WIDTH-1:0]      oe,
  output logic                  irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_word;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  final2_soc_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_in)
  );

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = sync_in & ~prev_in;
      EDGE_FALLING: edge_det = ~sync_in & prev_in;
      default:      edge_det = sync_in ^ prev_in;
    endcase
  end

  assign cap_clr = (wr_en && bus.address == ADDR_EDGE_CAPTURE) ? wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= RESET_VALUE;
      direction    <= RESET_DIR;
      irq_mask     <= '0;
      edge_capture <= '0;
      prev_in      <= '0;
    end else begin
      prev_in      <= sync_in;
      // New edges are OR'd in after the clear, so a coincident set survives.
      edge_capture <= (edge_capture & ~cap_clr) | (edge_det & ~direction);
      if (wr_en) begin
        case (bus.address)
          ADDR_DATA:      data_out  <= wdata;
          ADDR_DIRECTION: direction <= wdata;
          ADDR_IRQ_MASK:  irq_mask  <= wdata;
          ADDR_OUTSET:    data_out  <= data_out | wdata;
          ADDR_OUTCLEAR:  data_out  <= data_out & ~wdata;
          default:        ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_DATA:         rd_word = (direction & data_out) | (~direction & sync_in);
      ADDR_DIRECTION:    rd_word = direction;
      ADDR_IRQ_MASK:     rd_word = irq_mask;
      ADDR_EDGE_CAPTURE: rd_word = edge_capture;
      default:           rd_word = '0;
    endcase
  end

  assign bus.readdata = 32'(rd_word);
  assign out_port     = data_out;
  assign oe           = direction;
  assign irq          = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_final2_soc_pio_ext.sv
// Bench for final2_soc_pio_ext: a rising-edge/2-stage and an any-edge/3-stage
// instance share stimulus and are compared against a pin-history model.
module tb_final2_soc_pio_ext;

  localparam int unsigned W  = 8;
  localparam int unsigned SR = 2;
  localparam int unsigned SA = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    address;
  logic          cs;
  logic          wn;
  logic [31:0]   wd;
  logic [W-1:0]  in_port;
  logic [W-1:0]  out_r, oe_r, out_a, oe_a;
  logic          irq_r, irq_a;

  final2_soc_pio_ext_if bus_r ();
  final2_soc_pio_ext_if bus_a ();

  assign bus_r.address    = address;
  assign bus_r.chipselect = cs;
  assign bus_r.write_n    = wn;
  assign bus_r.writedata  = wd;
  assign bus_a.address    = address;
  assign bus_a.chipselect = cs;
  assign bus_a.write_n    = wn;
  assign bus_a.writedata  = wd;

  final2_soc_pio_ext #(
    .WIDTH(W), .RESET_VALUE(8'hA5), .RESET_DIR(8'hFF), .EDGE_TYPE(0), .SYNC_STAGES(SR)
  ) dut_r (
    .clk(clk), .reset(reset), .bus(bus_r.slave), .in_port(in_port),
    .out_port(out_r), .oe(oe_r), .irq(irq_r)
  );

  final2_soc_pio_ext #(
    .WIDTH(W), .RESET_VALUE(8'hA5), .RESET_DIR(8'hFF), .EDGE_TYPE(2), .SYNC_STAGES(SA)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_port),
    .out_port(out_a), .oe(oe_a), .irq(irq_a)
  );

  // Reference model: register values plus a history of sampled pin values.
  logic [W-1:0] m_dout, m_dir, m_mask, m_cap_r, m_cap_a;
  logic [W-1:0] hist [$];
  logic         m_valid = 1'b0;
  int           passed = 0;
  int           total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] edges_of(input int unsigned s, input int unsigned et);
    logic [W-1:0] cur, prv;
    cur = hist[s-1];
    prv = hist[s];
    if (et == 0)      return cur & ~prv;
    else if (et == 1) return ~cur & prv;
    else              return cur ^ prv;
  endfunction

  function automatic logic [31:0] exp_read(input int unsigned s, input logic [W-1:0] cap);
    logic [W-1:0] v;
    case (address)
      3'd0:    v = (m_dir & m_dout) | (~m_dir & hist[s-1]);
      3'd1:    v = m_dir;
      3'd2:    v = m_mask;
      3'd3:    v = cap;
      default: v = '0;
    endcase
    return {24'h0, v};
  endfunction

  task automatic model_edge();
    logic [W-1:0] er, ea, clr, d;
    if (reset) begin
      m_dout  = 8'hA5;
      m_dir   = 8'hFF;
      m_mask  = '0;
      m_cap_r = '0;
      m_cap_a = '0;
      hist    = '{8'h00, 8'h00, 8'h00, 8'h00};
      m_valid = 1'b1;
    end else begin
      er  = edges_of(SR, 0);
      ea  = edges_of(SA, 2);
      d   = wd[W-1:0];
      clr = (cs && !wn && address == 3'd3) ? d : '0;
      m_cap_r = (m_cap_r & ~clr) | (er & ~m_dir);
      m_cap_a = (m_cap_a & ~clr) | (ea & ~m_dir);
      if (cs && !wn) begin
        case (address)
          3'd0: m_dout = d;
          3'd1: m_dir  = d;
          3'd2: m_mask = d;
          3'd4: m_dout = m_dout | d;
          3'd5: m_dout = m_dout & ~d;
          default: ;
        endcase
      end
      hist.push_front(in_port);
      void'(hist.pop_back());
    end
  endtask

  // One clock: check reads before the edge, advance model, check outputs after.
  task automatic step();
    #1;
    if (m_valid) begin
      chk("read_rise", bus_r.readdata, exp_read(SR, m_cap_r));
      chk("read_any",  bus_a.readdata, exp_read(SA, m_cap_a));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("out_rise", {24'h0, out_r}, {24'h0, m_dout});
    chk("oe_rise",  {24'h0, oe_r},  {24'h0, m_dir});
    chk("irq_rise", {31'h0, irq_r}, {31'h0, |(m_cap_r & m_mask)});
    chk("out_any",  {24'h0, out_a}, {24'h0, m_dout});
    chk("oe_any",   {24'h0, oe_a},  {24'h0, m_dir});
    chk("irq_any",  {31'h0, irq_a}, {31'h0, |(m_cap_a & m_mask)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cs = 1'b0; wn = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wn = 1'b0; address = a; wd = d;
    step();
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rd_sel(input logic [2:0] a);
    cs = 1'b1; wn = 1'b1; address = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset with a concurrent DATA write that must lose.
    reset = 1'b1; cs = 1'b1; wn = 1'b0; address = 3'd0; wd = 32'h0000_0011; in_port = '0;
    step();
    step();
    reset = 1'b0;
    idle(1);
    chk("reset_out", {24'h0, out_r}, 32'h0000_00A5);
    chk("reset_oe",  {24'h0, oe_r},  32'h0000_00FF);
    chk("reset_irq", {31'h0, irq_r}, 32'h0);
    rd_sel(3'd2);
    chk("reset_mask_read", bus_r.readdata, 32'h0);
    idle(1);

    // DATA, OUTSET, OUTCLEAR back to back.
    wr(3'd0, 32'h0000_000F);
    chk("data_wr", {24'h0, out_r}, 32'h0000_000F);
    wr(3'd4, 32'hFFFF_FFF0);
    chk("outset", {24'h0, out_r}, 32'h0000_00FF);
    wr(3'd5, 32'h0000_0081);
    chk("outclear", {24'h0, out_r}, 32'h0000_007E);

    // Mixed DATA read: outputs from data_out, inputs from synchronised pins.
    in_port = 8'h30;
    wr(3'd1, 32'h0000_000F);
    wr(3'd0, 32'h0000_0005);
    idle(3);
    rd_sel(3'd0);
    chk("mixed_read_rise", bus_r.readdata, 32'h0000_0035);
    chk("mixed_read_any",  bus_a.readdata, 32'h0000_0035);
    idle(1);

    // Rising-edge capture latency and write-1-clear.
    wr(3'd1, 32'h0);
    idle(2);
    wr(3'd3, 32'h0000_00FF);
    wr(3'd2, 32'h0000_0002);
    idle(1);
    in_port = 8'h32;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (irq_r) begin
        lat = n;
        break;
      end
    end
    chk("irq_latency", 32'(lat), 32'(SR + 1));
    wr(3'd3, 32'h0000_0002);
    chk("irq_cleared", {31'h0, irq_r}, 32'h0);

    // Coincident set and write-1-clear: set wins.
    in_port = 8'h30;
    idle(5);
    wr(3'd3, 32'h0000_00FF);
    in_port = 8'h32;
    idle(SR);
    wr(3'd3, 32'h0000_0002);
    chk("collide_irq", {31'h0, irq_r}, 32'h1);
    rd_sel(3'd3);
    chk("collide_cap", bus_r.readdata, 32'h0000_0002);
    idle(1);
    wr(3'd3, 32'h0000_00FF);

    // Any-edge mode: toggles ignored while pin is an output, captured as input.
    wr(3'd1, 32'h0000_0004);
    wr(3'd3, 32'h0000_00FF);
    in_port = 8'h36;
    idle(5);
    in_port = 8'h32;
    idle(5);
    rd_sel(3'd3);
    chk("any_dir_out_nocap", {31'h0, bus_a.readdata[2]}, 32'h0);
    wr(3'd1, 32'h0);
    idle(2);
    in_port = 8'h36;
    idle(5);
    rd_sel(3'd3);
    chk("any_rise_cap", {31'h0, bus_a.readdata[2]}, 32'h1);
    wr(3'd3, 32'h0000_0004);
    in_port = 8'h32;
    idle(5);
    rd_sel(3'd3);
    chk("any_fall_cap", {31'h0, bus_a.readdata[2]}, 32'h1);
    idle(1);

    // Randomised traffic with occasional mid-operation reset.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      cs      = $urandom_range(0, 1) == 1;
      wn      = $urandom_range(0, 2) != 0;
      address = 3'($urandom_range(0, 7));
      wd      = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      step();
    end
    reset = 1'b0;
    idle(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
